// File: rtl/debounce_press_counter_pkg.sv
// Shared debounce settings and sizing helper for the debounce/counter stages.
package debounce_press_counter_pkg;

  // Default debounce settings shared by every stage that consumes the clean level.
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Number of bits needed to hold values 0 .. value-1 (minimum 1 bit).
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/debounce_press_counter_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module sync_chain
  import debounce_press_counter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // Plain shift chain: no logic between flops so metastability can settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_press_counter.sv
// Debouncer with rise/fall strobes and a wrapping count of debounced presses.
module debounce_press_counter
  import debounce_press_counter_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  output logic               q,
  output logic               rise,
  output logic               fall,
  output logic [COUNT_W-1:0] press_count
);

  localparam int CNT_W = clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             d_sync;
  logic [CNT_W-1:0] stable_cnt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (d),
    .q  (d_sync)
  );

  // Count consecutive cycles the synchronised input disagrees with q; accept it once stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt  <= '0;
      q           <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      press_count <= '0;
    end else if (d_sync == q) begin
      stable_cnt <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else if (stable_cnt == CNT_MAX) begin
      q          <= d_sync;
      stable_cnt <= '0;
      rise       <= d_sync;
      fall       <= ~d_sync;
      if (d_sync) begin
        press_count <= press_count + COUNT_W'(1);
      end
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
      rise       <= 1'b0;
      fall       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_press_counter.sv
// Scenario bench for debounce_press_counter: window-model scoreboard plus directed checks.
module tb_debounce_press_counter;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int CW     = 8;

  typedef struct packed {
    logic          q;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rst = 1'b1;
  logic          d   = 1'b0;
  logic          q;
  logic          rise;
  logic          fall;
  logic [CW-1:0] press_count;

  int total = 0;
  int bad   = 0;

  // Reference state: last STABLE samples of d, expected q and count, pending expectations.
  logic          hist[$];
  exp_t          sb_q[$];
  logic          m_q;
  logic [CW-1:0] m_cnt;
  logic          sb_on = 1'b0;

  debounce_press_counter #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .COUNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .q          (q),
    .rise       (rise),
    .fall       (fall),
    .press_count(press_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive d for the coming edge and push the expected outputs SYNC edges later.
  // q follows when the last STABLE samples all differ from the current q.
  task automatic record(input logic v);
    exp_t e;
    logic all_diff;
    d = v;
    hist.push_back(v);
    if (hist.size() > STABLE) void'(hist.pop_front());
    all_diff = 1'b1;
    foreach (hist[i]) if (hist[i] == m_q) all_diff = 1'b0;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (all_diff) begin
      m_q = ~m_q;
      e.rise = m_q;
      e.fall = ~m_q;
      if (m_q) m_cnt = m_cnt + 8'd1;
    end
    e.q   = m_q;
    e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    record(v);
  endtask

  // Hold reset two cycles, then release on a falling edge with d at d_init.
  task automatic do_reset(input logic d_init);
    sb_on = 1'b0;
    rst   = 1'b1;
    d     = d_init;
    repeat (2) @(negedge clk);
    hist.delete();
    repeat (STABLE) hist.push_back(1'b0);
    m_q   = 1'b0;
    m_cnt = '0;
    sb_q.delete();
    repeat (SYNC) sb_q.push_back('0);
    rst   = 1'b0;
    sb_on = 1'b1;
    record(d_init);
  endtask

  // Scoreboard monitor: pop one expectation per edge and compare.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb_on) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got no expectation at time %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if ({q, rise, fall, press_count} !== e) begin
          bad++;
          $display("FAIL sb_edge t=%0t: got q=%b rise=%b fall=%b cnt=%0d want q=%b rise=%b fall=%b cnt=%0d",
                   $time, q, rise, fall, press_count, e.q, e.rise, e.fall, e.cnt);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    d   = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || press_count !== '0) begin
      bad++;
      $display("FAIL reset_state: got q=%b rise=%b fall=%b cnt=%0d want all 0", q, rise, fall, press_count);
    end
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      @(posedge clk); #1;
      total++;
      if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || press_count !== '0) begin
        bad++;
        $display("FAIL idle_zero cycle%0d: got q=%b rise=%b fall=%b cnt=%0d want all 0",
                 i, q, rise, fall, press_count);
      end
    end
  endtask

  task automatic test_clean_press();
    logic          wq;
    logic          wr;
    logic [CW-1:0] wc;
    do_reset(1'b0);
    @(posedge clk); #1;
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1);
      @(posedge clk); #1;
      wq = (i >= 6);
      wr = (i == 6);
      wc = (i >= 6) ? 8'd1 : 8'd0;
      total++;
      if (q !== wq || rise !== wr || fall !== 1'b0 || press_count !== wc) begin
        bad++;
        $display("FAIL clean_press edge%0d: got q=%b rise=%b fall=%b cnt=%0d want q=%b rise=%b fall=0 cnt=%0d",
                 i, q, rise, fall, press_count, wq, wr, wc);
      end
    end
  endtask

  task automatic test_release();
    logic wq;
    logic wf;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0);
      @(posedge clk); #1;
      wq = (i < 6);
      wf = (i == 6);
      total++;
      if (q !== wq || fall !== wf || rise !== 1'b0 || press_count !== 8'd1) begin
        bad++;
        $display("FAIL release edge%0d: got q=%b rise=%b fall=%b cnt=%0d want q=%b rise=0 fall=%b cnt=1",
                 i, q, rise, fall, press_count, wq, wf);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      drive((i < 8) ? ((i % 2) == 0) : 1'b0);
      @(posedge clk); #1;
      total++;
      if (q !== 1'b0 || rise !== 1'b0 || press_count !== '0) begin
        bad++;
        $display("FAIL bounce cycle%0d: got q=%b rise=%b cnt=%0d want q=0 rise=0 cnt=0",
                 i, q, rise, press_count);
      end
    end
  endtask

  task automatic test_glitch();
    int nrise;
    int nfall;
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) begin
      drive(i < STABLE - 1);
      @(posedge clk); #1;
      total++;
      if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
        bad++;
        $display("FAIL glitch cycle%0d: got q=%b rise=%b fall=%b want q=0 rise=0 fall=0",
                 i, q, rise, fall);
      end
    end
    nrise = 0;
    nfall = 0;
    for (int i = 0; i < 14; i++) begin
      drive(i < STABLE);
      @(posedge clk); #1;
      if (rise === 1'b1) nrise++;
      if (fall === 1'b1) nfall++;
    end
    total++;
    if (nrise != 1 || nfall != 1 || press_count !== 8'd1) begin
      bad++;
      $display("FAIL stable_pulse: got rises=%0d falls=%0d cnt=%0d want rises=1 falls=1 cnt=1",
               nrise, nfall, press_count);
    end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] wc;
    do_reset(1'b0);
    for (int k = 1; k <= 256; k++) begin
      repeat (8) drive(1'b1);
      @(posedge clk); #1;
      if (k == 1 || k == 255 || k == 256) begin
        wc = CW'(k);
        total++;
        if (press_count !== wc) begin
          bad++;
          $display("FAIL wrap press%0d: got cnt=%0d want cnt=%0d", k, press_count, wc);
        end
      end
      repeat (8) drive(1'b0);
    end
  endtask

  task automatic test_async_reset();
    logic          wq;
    logic          wr;
    logic [CW-1:0] wc;
    do_reset(1'b0);
    repeat (8) drive(1'b1);
    repeat (8) drive(1'b0);
    repeat (4) drive(1'b1);
    @(posedge clk); #3;
    sb_on = 1'b0;
    rst   = 1'b1;
    #1;
    total++;
    if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || press_count !== '0 || dut.stable_cnt !== '0) begin
      bad++;
      $display("FAIL async_reset: got q=%b rise=%b fall=%b cnt=%0d stable_cnt=%0d want all 0",
               q, rise, fall, press_count, dut.stable_cnt);
    end
    do_reset(1'b1);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) drive(1'b1);
      @(posedge clk); #1;
      wq = (i >= SYNC + STABLE);
      wr = (i == SYNC + STABLE);
      wc = (i >= SYNC + STABLE) ? 8'd1 : 8'd0;
      total++;
      if (q !== wq || rise !== wr || press_count !== wc) begin
        bad++;
        $display("FAIL after_async edge%0d: got q=%b rise=%b cnt=%0d want q=%b rise=%b cnt=%0d",
                 i, q, rise, press_count, wq, wr, wc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_wrap();
    test_async_reset();
    sb_on = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
